// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, default sizing
// and the width-derivation helpers used by the top, its interface and sub-module.
package intc_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        ASSERT     = 2'b01,
        IN_SERVICE = 2'b10
    } state_t;

    localparam int DEF_NUM_SRC      = 4;
    localparam int DEF_PULSE_CYCLES = 2;

    // Source ID width: clog2 of the source count, never narrower than one bit.
    function automatic int id_width(input int num_src);
        return (num_src <= 2) ? 1 : $clog2(num_src);
    endfunction

    function automatic int cnt_width(input int pulse_cycles);
        return $clog2(pulse_cycles + 1);
    endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Request/mask/RTI inputs and interrupt status outputs of interrupt_controller.
// master = processor/requester side, slave = the controller.
interface interrupt_controller_if
    import intc_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int ID_W    = id_width(DEF_NUM_SRC)
);

    logic [NUM_SRC-1:0] irq;
    logic               mask_we;
    logic [NUM_SRC-1:0] mask_in;
    logic               rti;
    logic               intr;
    logic [ID_W-1:0]    irq_id;
    logic               in_service;
    logic [NUM_SRC-1:0] pending;

    modport master (
        output irq, mask_we, mask_in, rti,
        input  intr, irq_id, in_service, pending
    );

    modport slave (
        input  irq, mask_we, mask_in, rti,
        output intr, irq_id, in_service, pending
    );

endinterface

// File: rtl/intc_edge_detect.sv
// Per-line rising-edge detector producing a one-cycle rise vector.
// Define INT_SYNC_EN to insert a two-flop synchronizer ahead of the edge register.
module intc_edge_detect #(
    parameter int NUM_SRC = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq,
    output logic [NUM_SRC-1:0] rise
);

    logic [NUM_SRC-1:0] irq_s;
    logic [NUM_SRC-1:0] irq_q;

`ifdef INT_SYNC_EN
    localparam int PRIME_EDGES = 3;

    logic [NUM_SRC-1:0] sync1;
    logic [NUM_SRC-1:0] sync2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq;
            sync2 <= sync1;
        end
    end

    assign irq_s = sync2;
`else
    localparam int PRIME_EDGES = 1;

    assign irq_s = irq;
`endif

    // Edges are suppressed until the pipeline has sampled real line levels, so a
    // line already high across reset release is not mistaken for a new request.
    logic [1:0] prime_cnt;
    logic       primed;

    assign primed = (prime_cnt == 2'(PRIME_EDGES));

    always_ff @(posedge clk) begin
        if (!rst) begin
            irq_q     <= '0;
            prime_cnt <= '0;
        end else begin
            irq_q <= irq_s;
            if (!primed) prime_cnt <= prime_cnt + 2'd1;
        end
    end

    assign rise = primed ? (irq_s & ~irq_q) : '0;

endmodule

// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt controller: latches request edges, masks, arbitrates
// lowest index first and drives a stretched interrupt pulse. Optional macro: INT_SYNC_EN.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int NUM_SRC      = DEF_NUM_SRC,
    parameter int ID_W         = id_width(NUM_SRC),
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    interrupt_controller_if.slave  bus
);

    localparam int               CNT_W    = cnt_width(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES - 1);

    state_t             state;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] grant;
    logic [NUM_SRC-1:0] take;
    logic [ID_W-1:0]    winner;
    logic [CNT_W-1:0]   cnt;
    logic               intr;
    logic               in_service;
    logic [ID_W-1:0]    irq_id;

    intc_edge_detect #(
        .NUM_SRC (NUM_SRC)
    ) u_edge_detect (
        .clk  (clk),
        .rst  (rst),
        .irq  (bus.irq),
        .rise (rise)
    );

    assign eligible = pending & ~mask;

    // NOTE: every always_comb output gets a default before any conditional
    // assignment; otherwise unassigned paths infer latches.
    always_comb begin
        winner = '0;
        grant  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner   = ID_W'(i);
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

    assign take = (state == IDLE) ? grant : '0;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            mask       <= '0;
            pending    <= '0;
            cnt        <= '0;
            intr       <= 1'b0;
            in_service <= 1'b0;
            irq_id     <= '0;
        end else begin
            if (bus.mask_we) mask <= bus.mask_in;
            // Clearing the granted bit first lets a same-cycle edge on it win.
            pending <= (pending & ~take) | rise;

            case (state)
                IDLE: begin
                    if (|eligible) begin
                        state      <= ASSERT;
                        intr       <= 1'b1;
                        in_service <= 1'b1;
                        irq_id     <= winner;
                        cnt        <= CNT_LOAD;
                    end
                end
                ASSERT: begin
                    if (cnt == '0) begin
                        state <= IN_SERVICE;
                        intr  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                IN_SERVICE: begin
                    if (bus.rti) begin
                        state      <= IDLE;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    intr       <= 1'b0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

    assign bus.intr       = intr;
    assign bus.in_service = in_service;
    assign bus.irq_id     = irq_id;
    assign bus.pending    = pending;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scoreboard bench for interrupt_controller in its default build
// (NUM_SRC=4, PULSE_CYCLES=2, INT_SYNC_EN undefined).
module tb_interrupt_controller;

    typedef struct {
        string      tag;
        logic [7:0] value;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];

    interrupt_controller_if #(.NUM_SRC(4), .ID_W(2)) bus ();

    interrupt_controller #(
        .NUM_SRC      (4),
        .ID_W         (2),
        .PULSE_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Observed status word: {intr, in_service, irq_id[1:0], pending[3:0]}.
    logic [7:0] status;
    assign status = {bus.intr, bus.in_service, bus.irq_id, bus.pending};

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Push the expected post-edge status, clock once, then pop and compare.
    task automatic step(input string tag, input logic i, input logic s,
                        input logic [1:0] id, input logic [3:0] p);
        exp_t e;
        exp_q.push_back('{tag, {i, s, id, p}});
        tick();
        e = exp_q.pop_front();
        check(e.tag, status, e.value);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.irq     = '0;
        bus.mask_we = 1'b0;
        bus.mask_in = '0;
        bus.rti     = 1'b0;
        rst         = 1'b0;

        step("reset_a", 0, 0, 2'd0, 4'b0000);
        step("reset_b", 0, 0, 2'd0, 4'b0000);
        rst = 1'b1;
        step("release", 0, 0, 2'd0, 4'b0000);

        // Single request on source 2
        bus.irq = 4'b0100;
        step("single_pend", 0, 0, 2'd0, 4'b0100);
        bus.irq = 4'b0000;
        step("single_int_a", 1, 1, 2'd2, 4'b0000);
        step("single_int_b", 1, 1, 2'd2, 4'b0000);
        step("single_int_low", 0, 1, 2'd2, 4'b0000);
        step("single_wait", 0, 1, 2'd2, 4'b0000);
        bus.rti = 1'b1;
        step("single_rti", 0, 0, 2'd2, 4'b0000);
        bus.rti = 1'b0;

        // Priority: sources 3 and 1 together
        bus.irq = 4'b1010;
        step("prio_pend", 0, 0, 2'd2, 4'b1010);
        bus.irq = 4'b0000;
        step("prio_first_a", 1, 1, 2'd1, 4'b1000);
        step("prio_first_b", 1, 1, 2'd1, 4'b1000);
        step("prio_first_svc", 0, 1, 2'd1, 4'b1000);
        bus.rti = 1'b1;
        step("prio_rti", 0, 0, 2'd1, 4'b1000);
        bus.rti = 1'b0;
        step("prio_second_a", 1, 1, 2'd3, 4'b0000);
        step("prio_second_b", 1, 1, 2'd3, 4'b0000);
        step("prio_second_svc", 0, 1, 2'd3, 4'b0000);
        bus.rti = 1'b1;
        step("prio_rti2", 0, 0, 2'd3, 4'b0000);

        // Rti ignored in IDLE and in ASSERT
        step("rti_idle", 0, 0, 2'd3, 4'b0000);
        bus.rti = 1'b0;
        bus.irq = 4'b0001;
        step("rti_pend", 0, 0, 2'd3, 4'b0001);
        bus.irq = 4'b0000;
        bus.rti = 1'b1;
        step("rti_at_grant", 1, 1, 2'd0, 4'b0000);
        step("rti_in_assert", 1, 1, 2'd0, 4'b0000);
        bus.rti = 1'b0;
        step("rti_svc_a", 0, 1, 2'd0, 4'b0000);
        step("rti_svc_b", 0, 1, 2'd0, 4'b0000);
        bus.rti = 1'b1;
        step("rti_accept", 0, 0, 2'd0, 4'b0000);
        bus.rti = 1'b0;

        // Mask holds a pending bit; unmask releases it
        bus.mask_we = 1'b1;
        bus.mask_in = 4'b0001;
        step("mask_write", 0, 0, 2'd0, 4'b0000);
        bus.mask_we = 1'b0;
        bus.irq     = 4'b0001;
        step("mask_pend", 0, 0, 2'd0, 4'b0001);
        bus.irq = 4'b0000;
        step("mask_hold_a", 0, 0, 2'd0, 4'b0001);
        step("mask_hold_b", 0, 0, 2'd0, 4'b0001);
        bus.mask_we = 1'b1;
        bus.mask_in = 4'b0000;
        step("mask_old_used", 0, 0, 2'd0, 4'b0001);
        bus.mask_we = 1'b0;
        step("mask_release", 1, 1, 2'd0, 4'b0000);
        step("mask_int_b", 1, 1, 2'd0, 4'b0000);
        step("mask_svc", 0, 1, 2'd0, 4'b0000);

        // Rti and a new edge in the same cycle
        bus.rti = 1'b1;
        bus.irq = 4'b0100;
        step("rti_edge_same", 0, 0, 2'd0, 4'b0100);
        bus.rti = 1'b0;
        bus.irq = 4'b0000;
        step("rti_edge_int_a", 1, 1, 2'd2, 4'b0000);
        step("rti_edge_int_b", 1, 1, 2'd2, 4'b0000);
        step("rti_edge_svc", 0, 1, 2'd2, 4'b0000);
        bus.rti = 1'b1;
        step("rti_edge_done", 0, 0, 2'd2, 4'b0000);
        bus.rti = 1'b0;

        // New edge on the winner while its pending bit is being cleared
        bus.mask_we = 1'b1;
        bus.mask_in = 4'b0100;
        step("setwin_mask", 0, 0, 2'd2, 4'b0000);
        bus.mask_we = 1'b0;
        bus.irq     = 4'b0100;
        step("setwin_pend", 0, 0, 2'd2, 4'b0100);
        bus.irq = 4'b0000;
        step("setwin_hold", 0, 0, 2'd2, 4'b0100);
        bus.mask_we = 1'b1;
        bus.mask_in = 4'b0000;
        step("setwin_unmask", 0, 0, 2'd2, 4'b0100);
        bus.mask_we = 1'b0;
        bus.irq     = 4'b0100;
        step("setwin_grant", 1, 1, 2'd2, 4'b0100);
        bus.irq = 4'b0000;
        step("setwin_int_b", 1, 1, 2'd2, 4'b0100);
        step("setwin_svc", 0, 1, 2'd2, 4'b0100);
        bus.rti = 1'b1;
        step("setwin_rti", 0, 0, 2'd2, 4'b0100);
        bus.rti = 1'b0;
        step("setwin_b2b", 1, 1, 2'd2, 4'b0000);
        step("setwin_b2b_b", 1, 1, 2'd2, 4'b0000);
        step("setwin_b2b_svc", 0, 1, 2'd2, 4'b0000);
        bus.rti = 1'b1;
        step("setwin_done", 0, 0, 2'd2, 4'b0000);
        bus.rti = 1'b0;

        // Reset mid-pulse with requests pending; Irq[1] stays high throughout
        bus.irq = 4'b0111;
        step("rstmid_pend", 0, 0, 2'd2, 4'b0111);
        bus.irq = 4'b0010;
        step("rstmid_int", 1, 1, 2'd0, 4'b0110);
        rst = 1'b0;
        step("rstmid_reset", 0, 0, 2'd0, 4'b0000);
        rst = 1'b1;
        step("rstmid_release", 0, 0, 2'd0, 4'b0000);
        step("rstmid_no_edge_a", 0, 0, 2'd0, 4'b0000);
        step("rstmid_no_edge_b", 0, 0, 2'd0, 4'b0000);
        bus.irq = 4'b0000;
        step("rstmid_quiet", 0, 0, 2'd0, 4'b0000);

        check("scoreboard_drained", 8'(exp_q.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Collects up to NUM_SRC external interrupt request lines, latches rising edges as pending requests, arbitrates by fixed priority and drives the processor's single `Int` input with a stretched pulse plus the winning source ID. Sits directly upstream of the processor's interrupt input. Holds off further interrupts until the processor signals return-from-interrupt, so at most one interrupt is in service.

## Interface
- NUM_SRC, 4: number of request lines, 1..8
- ID_W, 2: width of the source ID, equal to clog2(NUM_SRC) with a minimum of 1
- PULSE_CYCLES, 2: cycles `Int` is held high per interrupt, ≥1
- Clk  in  1  clock; all state updates on its rising edge
- Rst  in  1  synchronous, active-low reset
- Irq  in  NUM_SRC  request lines; a rising edge raises a request
- Mask_We  in  1  write strobe for the mask register
- Mask_In  in  NUM_SRC  new mask value; 1 = source disabled
- Rti  in  1  one-cycle pulse from the processor when RTI completes
- Int  out  1  interrupt to the processor, registered
- Irq_Id  out  ID_W  ID of the source being signalled or in service, registered
- In_Service  out  1  high from `Int` assertion until `Rti` is accepted
- Pending  out  NUM_SRC  current pending register, masked bits included

## Operation
- **Edge detect:** register `Irq_q`. Per bit, `Irq & ~Irq_q` sets `pending[i]`.
- **Mask:** the mask register is written when `Mask_We` is high. A masked pending bit is kept, not dropped. It becomes eligible on the first cycle after it is unmasked.
- **Arbitration:** `eligible = pending & ~mask`. The lowest index wins.
- **FSM states:** IDLE, ASSERT, IN_SERVICE.
  - IDLE: if `eligible != 0` → ASSERT. On that edge: set `Int` = 1, latch `Irq_Id` = winner, clear `pending[winner]`, load `cnt` = PULSE_CYCLES-1.
  - ASSERT: `Int` = 1. If `cnt` == 0 → IN_SERVICE with `Int` = 0. Otherwise decrement `cnt`.
  - IN_SERVICE: `Int` = 0. When `Rti` = 1 → IDLE.
- `In_Service` = 1 in ASSERT and IN_SERVICE.
- `Rti` is ignored in IDLE and in ASSERT.
- **Simultaneous events:**
  - A new edge on the winner in the same cycle its pending bit is cleared: the set wins, so the bit stays 1.
  - `Mask_We` in the same cycle as arbitration: arbitration uses the old mask.
  - `Rti` and a new edge in the same cycle: the edge is latched and is served from IDLE on the following edge.
- No nesting. Requests arriving during service accumulate in `pending`, one bit per source; repeated edges on the same source coalesce.

## Timing
- **Reset values** (`Rst` = 0 at an edge): state = IDLE, `Int` = 0, `Irq_Id` = 0, `In_Service` = 0, `Pending` = 0, mask = 0 (all sources enabled), `Irq_q` = 0, `cnt` = 0.
- Reset mid-operation aborts any pulse and discards all pending requests.
- An `Irq` line already high when reset releases does not generate an edge. `Irq_q` samples it at the first edge after reset release.
- **Latency:** `Irq[i]` first seen high at edge k → `pending[i]` = 1 after edge k → `Int` = 1 after edge k+1, i.e. 2 cycles from request to `Int` (without INT_SYNC_EN).
- `Int` stays high for exactly PULSE_CYCLES cycles.
- **Back-to-back:** `Rti` seen at edge r with another eligible source → IDLE after r → `Int` = 1 after edge r+1.
- **Counter:** `cnt` width is clog2(PULSE_CYCLES+1). It never wraps; it reloads only on entry to ASSERT.

## Configuration
- **INT_SYNC_EN defined:** each `Irq` bit passes through a two-flop synchronizer before edge detection. The synchronizer flops reset to 0. Request-to-`Int` latency becomes 4 cycles.
- **INT_SYNC_EN undefined:** `Irq` is treated as synchronous to `Clk`. Latency is 2 cycles.

## Structure
- Shared package `intc_pkg` holds:
  - state encoding: IDLE = 2'b00, ASSERT = 2'b01, IN_SERVICE = 2'b10;
  - default NUM_SRC and PULSE_CYCLES constants;
  - the ID_W derivation function.
- One sub-module, `intc_edge_detect`. It is NUM_SRC wide and contains the optional synchronizer plus `Irq_q`. It outputs a one-cycle rise vector.
- FSM, arbiter, mask register and pending register live in `interrupt_controller`.

## Test plan
- **Single request:** pulse `Irq[2]` from reset with default parameters.
  - `Int` = 1 for exactly 2 cycles starting 2 cycles after the edge.
  - `Irq_Id` = 2; `Pending[2]` returns to 0.
- **Priority:** `Irq[3]` and `Irq[1]` rise in the same cycle.
  - First `Irq_Id` = 1; `Pending` = 4'b1000 during service.
  - After `Rti`, `Irq_Id` = 3 and `Int` rises one cycle later.
- **Mask:** write mask 4'b0001, then `Irq[0]` rises.
  - No `Int`; `Pending` = 4'b0001 holds.
  - Write mask 0 → `Int` rises 2 cycles after the write edge, with `Irq_Id` = 0.
- **Ignored Rti:** `Rti` pulsed in IDLE and during ASSERT.
  - No state change; `In_Service` stays high until a `Rti` pulse arrives in IN_SERVICE.
- **Reset mid-pulse:** `Rst` = 0 while `Int` = 1 with `Pending` = 4'b0110.
  - Next cycle `Int` = 0, `Pending` = 0, `In_Service` = 0.
  - A constantly high `Irq[1]` produces no interrupt after reset release.
- **Synchronizer** (INT_SYNC_EN defined): `Irq[0]` rises → `Int` = 1 exactly 4 cycles later.
